// File: rtl/somador_serial_ctrl.sv
// Wide serial adder/subtractor: one 4-bit ripple slice reused per nibble,
// LSB nibble first, with a registered carry and a start/busy/done handshake.
//
// Ports:
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        load request, honoured in IDLE or DONE
//   sub          0 = A + B + Cin, 1 = A - B (Cin ignored)
//   A, B, Cin    operands, sampled on the load edge
//   busy         high while nibbles are being processed
//   done         one-cycle pulse when S/Cout/OVF are final
//   S            W-bit result register (partial during RUN)
//   Cout         carry out of the MSB nibble (subtract: 1 = no borrow)
//   OVF          two's-complement overflow of the W-bit operation

module somador_4bits (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[4];

endmodule

module somador_serial_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 sub,
    input  logic [4*NIBBLES-1:0] A,
    input  logic [4*NIBBLES-1:0] B,
    input  logic                 Cin,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] S,
    output logic                 Cout,
    output logic                 OVF
);

    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic          carry;
    logic [IW-1:0] idx;

    logic          load;
    logic          step;
    logic          last;

    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [3:0]    nib_s;
    logic          nib_c;

    assign last = (idx == IW'(NIBBLES - 1));

    // Pick the current nibble of each operand.
    always_comb begin
        nib_a = '0;
        nib_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                nib_a = opa[4*i +: 4];
                nib_b = opb[4*i +: 4];
            end
        end
    end

    somador_4bits u_slice (
        .a    (nib_a),
        .b    (nib_b),
        .cin  (carry),
        .s    (nib_s),
        .cout (nib_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // DONE behaves like IDLE for accepting a new request, which gives
    // back-to-back operation without a bubble.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opa   <= '0;
            opb   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            OVF   <= 1'b0;
        end else if (load) begin
            // Subtract is A + ~B + 1, so the slice never needs a mode input.
            opa   <= A;
            opb   <= sub ? ~B : B;
            carry <= sub ? 1'b1 : Cin;
            idx   <= '0;
            S     <= '0;
            Cout  <= 1'b0;
            OVF   <= 1'b0;
        end else if (step) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx == IW'(i)) begin
                    S[4*i +: 4] <= nib_s;
                end
            end
            carry <= nib_c;
            if (last) begin
                idx  <= '0;
                Cout <= nib_c;
                // Same-sign operands yielding a different-sign result.
                OVF  <= (opa[W-1] == opb[W-1]) && (nib_s[3] != opa[W-1]);
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);

endmodule
